// File: rtl/pipe_alu_issue_ctrl.sv
// In-order issue scheduler in front of pipe_ALU: buffers instructions in a
// small FIFO and issues one per cycle, holding back read-after-write hazards.
module pipe_alu_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int HAZ_WIN = 2
) (
  input  logic        clk1,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_rs1,
  input  logic [3:0]  in_rs2,
  input  logic [3:0]  in_rd,
  input  logic [3:0]  in_func,
  input  logic [7:0]  in_addr,
  output logic [3:0]  rs1,
  output logic [3:0]  rs2,
  output logic [3:0]  rd,
  output logic [3:0]  func,
  output logic [7:0]  addr,
  output logic        issue_valid,
  output logic        idle,
  output logic [15:0] issue_cnt,
  output logic [15:0] stall_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [3:0] rd;
    logic [3:0] func;
    logic [7:0] addr;
  } instr_t;

  instr_t              mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]         count_q, count_d;
  logic [HAZ_WIN-1:0]  hist_v_q, hist_v_d;
  logic [3:0]          hist_rd_q [HAZ_WIN];
  logic [3:0]          hist_rd_d [HAZ_WIN];
  instr_t              out_q, out_d;
  logic [3:0]          vhist_q, vhist_d;
  logic [15:0]         issue_cnt_q, issue_cnt_d;
  logic [15:0]         stall_cnt_q, stall_cnt_d;

  instr_t head;
  instr_t in_instr;
  logic   non_empty, blocked, do_issue, push;

  // Handshake: an instruction transfers on the rising clk1 edge where
  // in_valid & in_ready; in_ready depends only on rst and the registered count,
  // so the source may drop or change in_valid freely while in_ready is low.
  assign in_ready = !rst && (count_q < (AW+1)'(DEPTH));
  assign push     = in_valid && in_ready;
  assign in_instr = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, func: in_func, addr: in_addr};

  always_comb begin
    head      = mem_q[rd_ptr_q];
    non_empty = (count_q != '0);
    blocked   = 1'b0;
    for (int i = 0; i < HAZ_WIN; i++) begin
      if (hist_v_q[i] && ((head.rs1 == hist_rd_q[i]) || (head.rs2 == hist_rd_q[i])))
        blocked = 1'b1;
    end
    do_issue = non_empty && !blocked;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_d       = out_q;
    issue_cnt_d = issue_cnt_q;
    stall_cnt_d = stall_cnt_q;
    hist_v_d    = hist_v_q;
    hist_rd_d   = hist_rd_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_issue) begin
      rd_ptr_d    = rd_ptr_q + AW'(1);
      out_d       = head;
      issue_cnt_d = issue_cnt_q + 16'd1;
    end
    if (non_empty && blocked) stall_cnt_d = stall_cnt_q + 16'd1;

    unique case ({push, do_issue})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    // Slot 0 mirrors the instruction now on the outputs; bubbles enter as invalid.
    hist_v_d[0]  = do_issue;
    hist_rd_d[0] = head.rd;
    for (int i = 1; i < HAZ_WIN; i++) begin
      hist_v_d[i]  = hist_v_q[i-1];
      hist_rd_d[i] = hist_rd_q[i-1];
    end

    vhist_d = {vhist_q[2:0], do_issue};
  end

  always_ff @(posedge clk1) begin
    if (push) mem_q[wr_ptr_q] <= in_instr;
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_q       <= '0;
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
      hist_v_q    <= '0;
      vhist_q     <= '0;
      for (int i = 0; i < HAZ_WIN; i++) hist_rd_q[i] <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_q       <= out_d;
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      hist_v_q    <= hist_v_d;
      vhist_q     <= vhist_d;
      hist_rd_q   <= hist_rd_d;
    end
  end

  // vhist covers every pipe_ALU stage, so idle means nothing is left in flight.
  assign issue_valid = vhist_q[0];
  assign idle        = (count_q == '0) && (vhist_q == 4'd0);
  assign rs1         = out_q.rs1;
  assign rs2         = out_q.rs2;
  assign rd          = out_q.rd;
  assign func        = out_q.func;
  assign addr        = out_q.addr;
  assign issue_cnt   = issue_cnt_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: doc/pipe_alu_issue_ctrl.md
Name: pipe_alu_issue_ctrl

Overview:
- In-order issue scheduler that sits in front of pipe_ALU.
- Buffers incoming ALU instructions (rs1, rs2, rd, func, addr) in a small FIFO and drives one instruction per cycle into the ALU operand ports.
- Stalls issue on read-after-write hazards against instructions still in the pipe.
- Exposes issue/stall counters and a pipeline-drained flag.

Parameters:
DEPTH, 4, input FIFO entries (power of 2, ≥2).
HAZ_WIN, 2, number of previously issued instructions whose rd blocks a dependent read (1..3); 2 matches pipe_ALU writeback timing.

Ports:
clk1  input  1  single clock, all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  instruction offered.
in_ready  output  1  FIFO can accept.
in_rs1  input  4  source register 1.
in_rs2  input  4  source register 2.
in_rd  input  4  destination register.
in_func  input  4  ALU function code.
in_addr  input  8  memory address for result store.
rs1  output  4  to ALU rs1.
rs2  output  4  to ALU rs2.
rd  output  4  to ALU rd.
func  output  4  to ALU func.
addr  output  8  to ALU addr.
issue_valid  output  1  outputs carry a new instruction this cycle; the ALU wrapper pipes this along as the write enable.
idle  output  1  FIFO empty and pipe drained.
issue_cnt  output  16  instructions issued, wraps at 2^16.
stall_cnt  output  16  hazard-stall cycles, wraps at 2^16.

Behaviour:
- Handshake:
  - Accept on the clk1 edge where in_valid & in_ready.
  - in_ready = !rst & (count < DEPTH), combinational from the registered count.
  - in_valid is allowed to drop or change while in_ready=0; nothing is latched then.
- FIFO:
  - Circular, in order. No bypass: an entry accepted at edge e is head-visible after e.
  - Push and pop in the same cycle are legal; count is unchanged.
- Hazard:
  - History shift register hist[1..HAZ_WIN] of {valid, rd}. hist[1] is the instruction currently on the outputs.
  - Head is blocked if, for any i ≤ HAZ_WIN, hist[i].valid & (head.rs1==hist[i].rd | head.rs2==hist[i].rd).
  - rd of the head itself is never compared (WAW needs no check because issue is in order).
- Issue:
  - At each edge with FIFO non-empty and no block: pop the head, register its fields onto the outputs, set issue_valid=1, issue_cnt+1.
  - Otherwise issue_valid=0 and the field outputs hold their previous values.
  - When FIFO is non-empty and blocked, stall_cnt+1.
  - Empty-FIFO cycles are not stalls.
  - hist shifts every cycle; a bubble enters as valid=0.
- Latency:
  - Minimum: accept at edge e, issue_valid high after edge e+1.
  - Dependent instruction issues ≥ HAZ_WIN+1 cycles after its producer.
- Throughput: one per cycle for independent instructions.
- idle = FIFO empty & no issue_valid in the last 4 cycles (4-bit valid shift register), covering all pipe_ALU stages.
- Reset (also mid-operation):
  - FIFO pointers and count cleared; queued instructions are discarded.
  - hist and idle-tracking valids cleared.
  - issue_valid=0; rs1/rs2/rd/func=0, addr=0.
  - issue_cnt=0, stall_cnt=0.
  - idle=1 after the reset edge; in_ready=0 while rst=1.

Test Plan:
1. Empty, push ADD(3,5→10,addr125), MUL(3,8→12,addr126) on consecutive edges → issue_valid high for 2 consecutive cycles starting one edge after the first accept; outputs match in order; issue_cnt=2, stall_cnt=0.
2. RAW on rs1: ADD(3,5→10) then SUB(10,5→14,addr128) back-to-back → SUB issues 3 cycles after ADD; stall_cnt=2; issue_cnt=2.
3. Distance-2 hazard on rs2: ADD(→10), MUL(3,8→12), SUB(7,10→13) → issues at t, t+1, t+3; stall_cnt=1.
4. Full FIFO: chain of 6 instructions each reading the previous rd (10→11→…), in_valid held high → in_ready drops once count=4; no instruction lost or duplicated; issue order preserved; each issue 3 cycles apart; stall_cnt=10.
5. Reset mid-op: 3 queued plus 1 in flight, pulse rst for 1 cycle → issue_valid=0, all fields 0, counters 0, idle=1 next cycle, queued entries never issued; a following ADD(3,5→10) issues with minimum latency.
6. Idle timing: single independent instruction → idle falls the cycle after accept and returns to 1 exactly 4 cycles after its issue_valid cycle.
